tron_game_ctrl: RTL and testbench
=================================

Name: tron_game_ctrl

Overview:
Top-level Tron game sequencer. It drives Game_State into the arena and renderer, and counts frames derived from frame_clk. It samples the arena's per-frame crash flags, keeps both players' scores, and runs the clear-arena handshake between rounds. It sits between the keyboard decode and the arena block.

Parameters:
WIN_SCORE, 3, rounds needed to win a game (1..15)
COUNT_FRAMES, 180, frames of pre-round countdown (1..255)
ROUND_END_FRAMES, 120, frames the round result is held on screen (1..255)

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  ~60 Hz frame clock (vsync domain)
Start  in  1  decoded start key (level; Enter)
Pause  in  1  decoded pause key (level)
Blue_Crash  in  1  arena: blue hit a trail or wall this frame
Red_Crash  in  1  arena: red hit a trail or wall this frame
Clear_Done  in  1  arena: trail memory wipe finished (1-cycle pulse)
Game_State  out  3  current state encoding
Blue_Score  out  4  blue rounds won
Red_Score  out  4  red rounds won
Round_Winner  out  2  00 none, 01 blue, 10 red, 11 draw
Clear_Req  out  1  level request to wipe the arena
Reset_Score  out  1  1-cycle pulse at new-game start
Countdown  out  8  frames remaining in COUNTDOWN, else 0

Behaviour:
- Reset low (async): state TITLE, scores 0, Round_Winner 00, Clear_Req 0, Reset_Score 0, Countdown 0, frame counter 0, synchronizers 0.
- frame_clk: 2-flop synchronizer plus rising-edge detect gives frame_tick, a 1-Clk pulse. Latency 3 Clk from the frame_clk edge.
- Start and Pause: rising edge detected internally (1-Clk pulse). Holding a key high does not retrigger.
- State encoding: TITLE=0, PLAY=1, CLEAR=2, COUNTDOWN=3, GAME_OVER=4, ROUND_END=5, PAUSED=6. 7 is unused and recovers to TITLE.
- TITLE: on start_edge, pulse Reset_Score, zero scores and go to CLEAR.
- CLEAR: Clear_Req=1. On Clear_Done, drop Clear_Req the next cycle, load Countdown=COUNT_FRAMES and go to COUNTDOWN. Clear_Done outside CLEAR is ignored.
- COUNTDOWN: decrement Countdown on each frame_tick. At the tick where it reaches 0, go to PLAY and set Round_Winner=00.
- PLAY: crash flags are sampled only on frame_tick.
  - Blue only crashed: red wins; Red_Score+1; Round_Winner=10.
  - Red only crashed: blue wins; Blue_Score+1; Round_Winner=01.
  - Both crashed on the same tick: draw; Round_Winner=11; no score change.
  - Any crash: load the frame counter with ROUND_END_FRAMES and go to ROUND_END.
- Scores saturate at 15. They are never incremented once one score equals WIN_SCORE.
- ROUND_END: decrement the frame counter per frame_tick. At 0: if either score equals WIN_SCORE go to GAME_OVER, else go to CLEAR. Round_Winner is held.
- GAME_OVER: scores and Round_Winner are held. On start_edge, pulse Reset_Score, zero scores and go to CLEAR.
- Simultaneous frame_tick and key edge: the key edge is evaluated first only in PAUSED and PLAY (pause). Start is ignored outside TITLE and GAME_OVER.
- All outputs are registered. Game_State changes 1 Clk after the triggering edge or pulse.

Optional Feature:
PAUSE_EN defined:
- In PLAY, pause_edge moves to PAUSED. Crash flags and frame_tick are ignored there.
- A pause_edge in PAUSED returns to PLAY.
- If pause_edge and a crash tick coincide, the pause wins and the crash is discarded.
PAUSE_EN undefined:
- The Pause port is present but ignored, and PAUSED is unreachable.

Decomposition:
- Package tron_pkg holds:
  - a game_state_t enum (3-bit, encodings above);
  - a winner_t enum (2-bit);
  - the SCORE_W=4 and FRAME_CNT_W=8 constants.
- The arena and renderer import the same package.
- Sub-module tron_edge_sync: 2-flop synchronizer plus rising-edge pulse, parameterless. It is instantiated for frame_clk, Start and Pause.

Test Plan:
- Reset low mid-PLAY with scores 2/1 -> immediately Game_State=0, scores 0/0, Clear_Req=0.
- Start pulse in TITLE -> Reset_Score high for exactly 1 Clk, Game_State=2, Clear_Req=1. Clear_Done pulse -> Game_State=3, Countdown=180, reaches PLAY after 180 frame_clk edges.
- In PLAY, assert Red_Crash at a frame edge -> Blue_Score=1, Round_Winner=01, Game_State=5. 120 frames later -> Game_State=2.
- Blue_Crash and Red_Crash on the same frame -> Round_Winner=11, scores unchanged.
- Blue wins 3 rounds -> Game_State=4 after ROUND_END, Blue_Score=3. Start -> Reset_Score pulse, scores 0/0, Game_State=2.
- With PAUSE_EN defined, Pause in PLAY -> Game_State=6 and Red_Crash is ignored for 10 frames; Pause again -> Game_State=1. Without PAUSE_EN -> Game_State stays 1.

Source files
------------

// File: rtl/tron_game_ctrl_pkg.sv
// Shared Tron types: game state and round winner encodings plus common widths.
// The arena and renderer import this package as well.
package tron_pkg;

  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    GS_TITLE     = 3'd0,
    GS_PLAY      = 3'd1,
    GS_CLEAR     = 3'd2,
    GS_COUNTDOWN = 3'd3,
    GS_GAME_OVER = 3'd4,
    GS_ROUND_END = 3'd5,
    GS_PAUSED    = 3'd6
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_BLUE = 2'b01,
    WIN_RED  = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

endpackage

// File: rtl/tron_game_ctrl_if.sv
// Game controller bus: keyboard/arena inputs and sequencer outputs.
// slave = controller side, master = keyboard/arena/testbench side.
interface tron_game_ctrl_if;
  import tron_pkg::*;

  logic                   frame_clk;
  logic                   Start;
  logic                   Pause;
  logic                   Blue_Crash;
  logic                   Red_Crash;
  logic                   Clear_Done;
  logic [2:0]             Game_State;
  logic [SCORE_W-1:0]     Blue_Score;
  logic [SCORE_W-1:0]     Red_Score;
  logic [1:0]             Round_Winner;
  logic                   Clear_Req;
  logic                   Reset_Score;
  logic [FRAME_CNT_W-1:0] Countdown;

  modport master (
    output frame_clk, Start, Pause, Blue_Crash, Red_Crash, Clear_Done,
    input  Game_State, Blue_Score, Red_Score, Round_Winner, Clear_Req,
           Reset_Score, Countdown
  );

  modport slave (
    input  frame_clk, Start, Pause, Blue_Crash, Red_Crash, Clear_Done,
    output Game_State, Blue_Score, Red_Score, Round_Winner, Clear_Req,
           Reset_Score, Countdown
  );

endinterface

// File: rtl/tron_game_ctrl_edge_sync.sv
// tron_edge_sync: 2-flop synchronizer followed by a registered rising-edge
// pulse. The pulse is high for one clk, 3 clks after the input edge.
module tron_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic       pulse_q;

  // Shift the input through the sync chain and register the rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], d_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/tron_game_ctrl.sv
// tron_game_ctrl: Tron round/game sequencer. Counts synchronized frames,
// scores crashes and runs the clear-arena handshake between rounds.
// Optional macro PAUSE_EN enables the PLAY <-> PAUSED toggle on the Pause key.
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int unsigned WIN_SCORE        = 3,
  parameter int unsigned COUNT_FRAMES     = 180,
  parameter int unsigned ROUND_END_FRAMES = 120
) (
  input  logic             Clk,
  input  logic             Reset,
  tron_game_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_TITLE     = GS_TITLE;
  localparam logic [2:0] ST_PLAY      = GS_PLAY;
  localparam logic [2:0] ST_CLEAR     = GS_CLEAR;
  localparam logic [2:0] ST_COUNTDOWN = GS_COUNTDOWN;
  localparam logic [2:0] ST_GAME_OVER = GS_GAME_OVER;
  localparam logic [2:0] ST_ROUND_END = GS_ROUND_END;
  localparam logic [2:0] ST_PAUSED    = GS_PAUSED;

  localparam logic [SCORE_W-1:0]     WIN_Q   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]     SAT_Q   = '1;
  localparam logic [FRAME_CNT_W-1:0] COUNT_Q = FRAME_CNT_W'(COUNT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] RE_Q    = FRAME_CNT_W'(ROUND_END_FRAMES);

  logic frame_tick;
  logic start_edge;
  logic crash_tick;

  logic [2:0]             state_q, state_d;
  logic [SCORE_W-1:0]     blue_q, blue_d, red_q, red_d;
  logic [1:0]             winner_q, winner_d;
  logic                   clear_req_q, clear_req_d;
  logic                   reset_score_q, reset_score_d;
  logic [FRAME_CNT_W-1:0] countdown_q, countdown_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   score_open;

  tron_edge_sync u_frame_sync (.clk_i(Clk), .rst_ni(Reset), .d_i(bus.frame_clk), .pulse_o(frame_tick));
  tron_edge_sync u_start_sync (.clk_i(Clk), .rst_ni(Reset), .d_i(bus.Start),     .pulse_o(start_edge));

`ifdef PAUSE_EN
  logic pause_edge;
  tron_edge_sync u_pause_sync (.clk_i(Clk), .rst_ni(Reset), .d_i(bus.Pause),     .pulse_o(pause_edge));
  // A pause press wins over a crash on the same tick.
  assign crash_tick = frame_tick & (bus.Blue_Crash | bus.Red_Crash) & ~pause_edge;
`else
  assign crash_tick = frame_tick & (bus.Blue_Crash | bus.Red_Crash);
`endif

  // Once either player has reached the winning score, scores are frozen.
  assign score_open = (blue_q != WIN_Q) && (red_q != WIN_Q);

  // Next-state logic for the sequencer, scores and frame counters.
  always_comb begin
    state_d       = state_q;
    blue_d        = blue_q;
    red_d         = red_q;
    winner_d      = winner_q;
    countdown_d   = countdown_q;
    frame_cnt_d   = frame_cnt_q;
    reset_score_d = 1'b0;
    case (state_q)
      ST_TITLE, ST_GAME_OVER: begin
        if (start_edge) begin
          reset_score_d = 1'b1;
          blue_d        = '0;
          red_d         = '0;
          state_d       = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (bus.Clear_Done) begin
          countdown_d = COUNT_Q;
          state_d     = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_tick) begin
          if (countdown_q <= 1) begin
            countdown_d = '0;
            winner_d    = WIN_NONE;
            state_d     = ST_PLAY;
          end else begin
            countdown_d = countdown_q - 1'b1;
          end
        end
      end
      ST_PLAY: begin
`ifdef PAUSE_EN
        if (pause_edge) state_d = ST_PAUSED;
`endif
        if (crash_tick) begin
          if (bus.Blue_Crash && bus.Red_Crash) begin
            winner_d = WIN_DRAW;
          end else if (bus.Blue_Crash) begin
            winner_d = WIN_RED;
            if (score_open && red_q != SAT_Q) red_d = red_q + 1'b1;
          end else begin
            winner_d = WIN_BLUE;
            if (score_open && blue_q != SAT_Q) blue_d = blue_q + 1'b1;
          end
          frame_cnt_d = RE_Q;
          state_d     = ST_ROUND_END;
        end
      end
      ST_ROUND_END: begin
        if (frame_tick) begin
          if (frame_cnt_q <= 1) begin
            frame_cnt_d = '0;
            state_d     = (blue_q == WIN_Q || red_q == WIN_Q) ? ST_GAME_OVER : ST_CLEAR;
          end else begin
            frame_cnt_d = frame_cnt_q - 1'b1;
          end
        end
      end
      ST_PAUSED: begin
`ifdef PAUSE_EN
        if (pause_edge) state_d = ST_PLAY;
`else
        state_d = ST_TITLE;
`endif
      end
      default: state_d = ST_TITLE;
    endcase
    clear_req_d = (state_d == ST_CLEAR);
  end

  // Register all state and outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_TITLE;
      blue_q        <= '0;
      red_q         <= '0;
      winner_q      <= WIN_NONE;
      clear_req_q   <= 1'b0;
      reset_score_q <= 1'b0;
      countdown_q   <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      blue_q        <= blue_d;
      red_q         <= red_d;
      winner_q      <= winner_d;
      clear_req_q   <= clear_req_d;
      reset_score_q <= reset_score_d;
      countdown_q   <= countdown_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.Game_State   = state_q;
  assign bus.Blue_Score   = blue_q;
  assign bus.Red_Score    = red_q;
  assign bus.Round_Winner = winner_q;
  assign bus.Clear_Req    = clear_req_q;
  assign bus.Reset_Score  = reset_score_q;
  assign bus.Countdown    = countdown_q;

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Directed testbench for tron_game_ctrl with hand-computed expectations.
// Works in both builds (PAUSE_EN defined or not).
module tb_tron_game_ctrl;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  tron_game_ctrl_if bus();

  tron_game_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One frame_clk period: flags held across the whole synchronized tick.
  task automatic frame(input logic blue, input logic red);
    @(negedge Clk);
    bus.Blue_Crash = blue;
    bus.Red_Crash  = red;
    bus.frame_clk  = 1'b1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.frame_clk  = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.Blue_Crash = 1'b0;
    bus.Red_Crash  = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic clear_done_pulse();
    @(negedge Clk);
    bus.Clear_Done = 1'b1;
    @(negedge Clk);
    bus.Clear_Done = 1'b0;
    @(negedge Clk);
  endtask

  // Press and hold Start for 10 cycles; returns how many cycles Reset_Score was high.
  task automatic press_start(output int pulses);
    pulses = 0;
    @(negedge Clk);
    bus.Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.Reset_Score) pulses++;
    end
    bus.Start = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic press_pause();
    @(negedge Clk);
    bus.Pause = 1'b1;
    repeat (8) @(negedge Clk);
    bus.Pause = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // Clear handshake then full countdown into PLAY.
  task automatic next_round();
    clear_done_pulse();
    frames(180);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    bus.frame_clk  = 1'b0;
    bus.Start      = 1'b0;
    bus.Pause      = 1'b0;
    bus.Blue_Crash = 1'b0;
    bus.Red_Crash  = 1'b0;
    bus.Clear_Done = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(bus.Game_State), 0);
    check("rst_blue", 32'(bus.Blue_Score), 0);
    check("rst_red", 32'(bus.Red_Score), 0);
    check("rst_winner", 32'(bus.Round_Winner), 0);
    check("rst_clear_req", 32'(bus.Clear_Req), 0);
    check("rst_countdown", 32'(bus.Countdown), 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Clear_Done in TITLE is ignored.
    clear_done_pulse();
    check("title_ignore_clear_done", 32'(bus.Game_State), 0);

    // New game from TITLE.
    press_start(pulses);
    check("start_reset_score_pulses", 32'(pulses), 1);
    check("start_state_clear", 32'(bus.Game_State), 2);
    check("start_clear_req", 32'(bus.Clear_Req), 1);

    clear_done_pulse();
    check("cd_state_countdown", 32'(bus.Game_State), 3);
    check("cd_countdown_180", 32'(bus.Countdown), 180);
    check("cd_clear_req_low", 32'(bus.Clear_Req), 0);
    frame(1'b0, 1'b0);
    check("countdown_dec", 32'(bus.Countdown), 179);
    frames(178);
    check("countdown_last", 32'(bus.Countdown), 1);
    check("countdown_still", 32'(bus.Game_State), 3);
    frame(1'b0, 1'b0);
    check("play_state", 32'(bus.Game_State), 1);
    check("play_countdown0", 32'(bus.Countdown), 0);
    check("play_winner_none", 32'(bus.Round_Winner), 0);

    // Round 1: red crashes, blue scores.
    frame(1'b0, 1'b1);
    check("r1_state", 32'(bus.Game_State), 5);
    check("r1_blue", 32'(bus.Blue_Score), 1);
    check("r1_winner", 32'(bus.Round_Winner), 1);
    frames(119);
    check("r1_hold", 32'(bus.Game_State), 5);
    check("r1_hold_winner", 32'(bus.Round_Winner), 1);
    frame(1'b0, 1'b0);
    check("r1_to_clear", 32'(bus.Game_State), 2);
    check("r1_clear_req", 32'(bus.Clear_Req), 1);
    next_round();
    check("r2_play", 32'(bus.Game_State), 1);

    // Round 2: draw.
    frame(1'b1, 1'b1);
    check("r2_winner_draw", 32'(bus.Round_Winner), 3);
    check("r2_blue", 32'(bus.Blue_Score), 1);
    check("r2_red", 32'(bus.Red_Score), 0);
    frames(120);
    check("r2_to_clear", 32'(bus.Game_State), 2);
    next_round();

    // Round 3: blue crashes, red scores.
    frame(1'b1, 1'b0);
    check("r3_red", 32'(bus.Red_Score), 1);
    check("r3_winner", 32'(bus.Round_Winner), 2);
    frames(120);
    next_round();

    // Rounds 4 and 5: blue reaches 3.
    frame(1'b0, 1'b1);
    check("r4_blue", 32'(bus.Blue_Score), 2);
    frames(120);
    check("r4_to_clear", 32'(bus.Game_State), 2);
    next_round();
    frame(1'b0, 1'b1);
    check("r5_blue", 32'(bus.Blue_Score), 3);
    frames(120);
    check("game_over_state", 32'(bus.Game_State), 4);
    check("game_over_blue", 32'(bus.Blue_Score), 3);
    check("game_over_red", 32'(bus.Red_Score), 1);
    check("game_over_winner", 32'(bus.Round_Winner), 1);
    clear_done_pulse();
    check("go_ignore_clear_done", 32'(bus.Game_State), 4);

    // Restart from GAME_OVER.
    press_start(pulses);
    check("restart_pulses", 32'(pulses), 1);
    check("restart_blue", 32'(bus.Blue_Score), 0);
    check("restart_red", 32'(bus.Red_Score), 0);
    check("restart_state", 32'(bus.Game_State), 2);
    next_round();
    check("g2_play", 32'(bus.Game_State), 1);

    // Start in PLAY is ignored.
    press_start(pulses);
    check("play_start_ignored", 32'(bus.Game_State), 1);
    check("play_start_no_pulse", 32'(pulses), 0);

    // Pause behaviour.
    press_pause();
`ifdef PAUSE_EN
    check("pause_state", 32'(bus.Game_State), 6);
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b1);
    check("paused_hold", 32'(bus.Game_State), 6);
    check("paused_blue", 32'(bus.Blue_Score), 0);
    press_pause();
    check("unpause_state", 32'(bus.Game_State), 1);
`else
    check("pause_ignored", 32'(bus.Game_State), 1);
`endif
    frame(1'b0, 1'b1);
    check("g2_r1_state", 32'(bus.Game_State), 5);
    check("g2_r1_blue", 32'(bus.Blue_Score), 1);
    frames(120);
    next_round();
    check("g2_r2_play", 32'(bus.Game_State), 1);

    // Asynchronous reset mid-PLAY.
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.Game_State), 0);
    check("async_rst_blue", 32'(bus.Blue_Score), 0);
    check("async_rst_clear_req", 32'(bus.Clear_Req), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    check("post_rst_title", 32'(bus.Game_State), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
